// File: rtl/bus_host_bridge_if.sv
// Host-side request/response channel of bus_host_bridge.
// The bridge plays the slave role; the command source (UART/SPI decoder, CPU shim) is the master.
interface bus_host_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/bus_host_bridge.sv
// Single-outstanding register-bus master: turns one host request into a one-cycle bus_rd_req or
// bus_wr_req pulse, waits for the matching ack (with timeout) and returns a held response.
module bus_host_bridge #(
   parameter  int unsigned TIMEOUT        = 255,
   parameter  int unsigned BUS_ADDR_WIDTH = 32,
   parameter  int unsigned BUS_DATA_WIDTH = 32,
   localparam int unsigned BUS_IN_WIDTH   = BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 4,
   localparam int unsigned BUS_OUT_WIDTH  = BUS_DATA_WIDTH + 3
) (
   input  logic                     bus_clk,
   input  logic                     bus_reset_l,
   bus_host_bridge_if.slave         host,
   output logic                     irq,
   output logic [BUS_IN_WIDTH-1:0]  bus_in,
   input  logic [BUS_OUT_WIDTH-1:0] bus_out
);
   // bus_out layout, LSB first: rd_data, rd_ack, wr_ack, irq
   localparam int unsigned FIELD_RD_DATA = 0;
   localparam int unsigned FIELD_RD_ACK  = BUS_DATA_WIDTH;
   localparam int unsigned FIELD_WR_ACK  = BUS_DATA_WIDTH + 1;
   localparam int unsigned FIELD_IRQ     = BUS_DATA_WIDTH + 2;

   localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   state_e                    state_q;
   logic                      we_q;
   logic [BUS_ADDR_WIDTH-1:0] addr_q;
   logic [BUS_DATA_WIDTH-1:0] wr_data_q;
   logic                      rd_req_q;
   logic                      wr_req_q;
   logic [CNT_WIDTH-1:0]      cnt_q;
   logic                      resp_valid_q;
   logic [BUS_DATA_WIDTH-1:0] resp_rdata_q;
   logic                      resp_err_q;

   logic                      ack_s;
   logic [BUS_DATA_WIDTH-1:0] rd_data_s;

   // Only the ack type matching the outstanding request counts.
   assign ack_s     = we_q ? bus_out[FIELD_WR_ACK] : bus_out[FIELD_RD_ACK];
   assign rd_data_s = bus_out[FIELD_RD_DATA +: BUS_DATA_WIDTH];

   assign irq = bus_out[FIELD_IRQ];

   // bus_in layout, LSB first: clk, reset_l, addr, wr_data, rd_req, wr_req
   assign bus_in = {wr_req_q, rd_req_q, wr_data_q, addr_q, bus_reset_l, bus_clk};

   assign host.req_ready  = (state_q == ST_IDLE) && bus_reset_l;
   assign host.resp_valid = resp_valid_q;
   assign host.resp_rdata = resp_rdata_q;
   assign host.resp_err   = resp_err_q;

   // Transaction FSM with all bus and response outputs registered.
   always_ff @(posedge bus_clk) begin
      if (!bus_reset_l) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wr_data_q    <= '0;
         rd_req_q     <= 1'b0;
         wr_req_q     <= 1'b0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (host.req_valid) begin
                  we_q      <= host.req_we;
                  addr_q    <= host.req_addr;
                  wr_data_q <= host.req_wdata;
                  wr_req_q  <= host.req_we;
                  rd_req_q  <= !host.req_we;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               rd_req_q <= 1'b0;
               wr_req_q <= 1'b0;
               cnt_q    <= '0;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               // An ack in the expiry cycle still yields a normal response.
               if (ack_s) begin
                  resp_rdata_q <= we_q ? '0 : rd_data_s;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  resp_rdata_q <= '1;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            ST_RESP: begin
               if (host.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               rd_req_q     <= 1'b0;
               wr_req_q     <= 1'b0;
               resp_valid_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bus_host_bridge.sv
// Scoreboard bench for bus_host_bridge: directed host requests against a small register-slave
// model plus forced acks; a negedge monitor checks responses, pulses and hold behaviour.
module tb_bus_host_bridge;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned TO    = 8;
   localparam int unsigned IN_W  = AW + DW + 4;
   localparam int unsigned OUT_W = DW + 3;
   localparam int F_RST    = 1;
   localparam int F_ADDR   = 2;
   localparam int F_WDATA  = 2 + AW;
   localparam int F_RD_REQ = 2 + AW + DW;
   localparam int F_WR_REQ = 3 + AW + DW;

   logic             bus_clk = 1'b0;
   logic             bus_reset_l;
   logic             irq;
   logic [IN_W-1:0]  bus_in;
   logic [OUT_W-1:0] bus_out;

   bus_host_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif ();

   bus_host_bridge #(.TIMEOUT(TO), .BUS_ADDR_WIDTH(AW), .BUS_DATA_WIDTH(DW)) dut (
      .bus_clk     (bus_clk),
      .bus_reset_l (bus_reset_l),
      .host        (hif),
      .irq         (irq),
      .bus_in      (bus_in),
      .bus_out     (bus_out)
   );

   always #5 bus_clk = ~bus_clk;

   // Register slave: four words at 0x10..0x1C, single-cycle ack, data only alongside rd_ack.
   logic [31:0] mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
   logic        s_rd_ack, s_wr_ack, slave_irq, f_rd_ack, f_wr_ack;
   logic [31:0] s_rd_data, f_rdata;
   logic [31:0] b_addr, b_wdata;
   logic        b_rd_req, b_wr_req, mapped;
   assign b_addr   = bus_in[F_ADDR +: AW];
   assign b_wdata  = bus_in[F_WDATA +: DW];
   assign b_rd_req = bus_in[F_RD_REQ];
   assign b_wr_req = bus_in[F_WR_REQ];
   assign mapped   = (b_addr[31:4] == 28'h1);
   assign bus_out  = {slave_irq, s_wr_ack | f_wr_ack, s_rd_ack | f_rd_ack, s_rd_data | f_rdata};

   always @(posedge bus_clk) begin
      if (!bus_reset_l) begin
         s_rd_ack  <= 1'b0;
         s_wr_ack  <= 1'b0;
         s_rd_data <= 32'h0;
      end else begin
         s_rd_ack  <= b_rd_req && mapped;
         s_wr_ack  <= b_wr_req && mapped;
         s_rd_data <= (b_rd_req && mapped) ? mem[b_addr[3:2]] : 32'h0;
         if (b_wr_req && mapped) mem[b_addr[3:2]] <= b_wdata;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          vcyc;
   } exp_t;
   exp_t sb[$];

   int   checks = 0, failures = 0;
   int   cyc = 0;
   int   acc_cyc = -10, last_hs_cyc = -10, acc_cnt = 0, pulse_cnt = 0;
   logic acc_we = 1'b0;

   always @(posedge bus_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Drive one request; called and returning on a falling edge.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata_exp, input logic err_exp, input int lat,
                        input bit exp_resp, input bit gap_chk, input bit hold);
      int n = 0;
      hif.req_we    = we;
      hif.req_addr  = addr;
      hif.req_wdata = wdata;
      hif.req_valid = 1'b1;
      #2;
      while (hif.req_ready !== 1'b1 && n < 200) begin
         @(negedge bus_clk);
         #2;
         n++;
      end
      if (hif.req_ready !== 1'b1) begin
         fail("accept_timeout");
      end else begin
         acc_cyc = cyc;
         acc_we  = we;
         acc_cnt++;
         if (exp_resp) sb.push_back('{rdata_exp, err_exp, cyc + lat});
         if (gap_chk) chk("accept_gap", 64'(cyc), 64'(last_hs_cyc + 1));
      end
      @(negedge bus_clk);
      if (!hold) hif.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge bus_clk);
         n++;
      end
      if (sb.size() != 0) fail("drain_timeout");
   endtask

   logic        pv = 1'b0, pr = 1'b0, pe = 1'b0;
   logic [31:0] pd = 32'h0;
   exp_t        e;

   // Monitor: pulse timing, response timing/content, hold stability, req_ready masking.
   initial begin
      forever begin
         @(negedge bus_clk);
         #1;
         if (bus_reset_l === 1'b1) begin
            if (bus_in[F_RD_REQ] === 1'b1 || bus_in[F_WR_REQ] === 1'b1) begin
               pulse_cnt++;
               chk("pulse_cycle", 64'(cyc), 64'(acc_cyc + 1));
               chk("pulse_type", 64'(bus_in[F_WR_REQ]), 64'(acc_we));
               chk("pulse_onehot", 64'(bus_in[F_RD_REQ] ^ bus_in[F_WR_REQ]), 64'd1);
            end
            if (hif.resp_valid === 1'b1) begin
               chk("req_ready_in_resp", 64'(hif.req_ready), 64'd0);
               if (!pv) begin
                  if (sb.size() == 0) fail("unexpected_resp");
                  else chk("resp_cycle", 64'(cyc), 64'(sb[0].vcyc));
               end else if (!pr) begin
                  chk("hold_rdata", 64'(hif.resp_rdata), 64'(pd));
                  chk("hold_err", 64'(hif.resp_err), 64'(pe));
               end
               if (hif.resp_ready === 1'b1 && sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("resp_rdata", 64'(hif.resp_rdata), 64'(e.rdata));
                  chk("resp_err", 64'(hif.resp_err), 64'(e.err));
                  last_hs_cyc = cyc;
               end
            end
            pv = (hif.resp_valid === 1'b1);
            pr = (hif.resp_ready === 1'b1);
            pd = hif.resp_rdata;
            pe = hif.resp_err;
         end else begin
            pv = 1'b0;
         end
      end
   end

   task automatic chk_reset_outputs();
      chk("rst_req_ready", 64'(hif.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(hif.resp_valid), 64'd0);
      chk("rst_resp_rdata", 64'(hif.resp_rdata), 64'd0);
      chk("rst_resp_err", 64'(hif.resp_err), 64'd0);
      chk("rst_rd_req", 64'(bus_in[F_RD_REQ]), 64'd0);
      chk("rst_wr_req", 64'(bus_in[F_WR_REQ]), 64'd0);
      chk("rst_addr", 64'(b_addr), 64'd0);
      chk("rst_wdata", 64'(b_wdata), 64'd0);
      chk("rst_fwd", 64'(bus_in[F_RST]), 64'd0);
   endtask

   initial begin
      int n;
      hif.req_valid = 1'b0; hif.req_we = 1'b0; hif.req_addr = 32'h0; hif.req_wdata = 32'h0;
      hif.resp_ready = 1'b1;
      f_rd_ack = 1'b0; f_wr_ack = 1'b0; f_rdata = 32'h0; slave_irq = 1'b0;
      bus_reset_l = 1'b0;
      repeat (3) @(negedge bus_clk);
      #1 chk_reset_outputs();
      @(negedge bus_clk);
      bus_reset_l = 1'b1;
      #1 chk("req_ready_after_rst", 64'(hif.req_ready), 64'd1);
      chk("rst_fwd_high", 64'(bus_in[F_RST]), 64'd1);
      slave_irq = 1'b1;
      #1 chk("irq_high", 64'(irq), 64'd1);
      slave_irq = 1'b0;
      #1 chk("irq_low", 64'(irq), 64'd0);
      @(negedge bus_clk);

      // Single write then read-back.
      issue(1'b1, 32'h10, 32'h0000_1234, 32'h0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      wait_drain();
      issue(1'b0, 32'h10, 32'h0, 32'h0000_1234, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // Back-to-back with req_valid held.
      issue(1'b1, 32'h14, 32'hA5A5_0001, 32'h0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
      issue(1'b1, 32'h18, 32'h5A5A_0002, 32'h0, 1'b0, 3, 1'b1, 1'b1, 1'b1);
      issue(1'b0, 32'h18, 32'h0, 32'h5A5A_0002, 1'b0, 3, 1'b1, 1'b1, 1'b1);
      issue(1'b0, 32'h14, 32'h0, 32'hA5A5_0001, 1'b0, 3, 1'b1, 1'b1, 1'b0);
      wait_drain();

      // Response stalled for 10 cycles while the next request waits.
      hif.resp_ready = 1'b0;
      issue(1'b0, 32'h10, 32'h0, 32'h0000_1234, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      fork
         issue(1'b1, 32'h1C, 32'h0BAD_F00D, 32'h0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
         begin
            n = 0;
            while (hif.resp_valid !== 1'b1 && n < 50) begin
               @(negedge bus_clk);
               n++;
            end
            repeat (10) @(negedge bus_clk);
            hif.resp_ready = 1'b1;
         end
      join
      wait_drain();
      issue(1'b0, 32'h1C, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      wait_drain();

      // Wrong-type ack ignored; matching ack in the last WAIT cycle wins over expiry.
      fork
         issue(1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, 1'b0, 10, 1'b1, 1'b0, 1'b0);
         begin
            n = 0;
            do begin
               @(negedge bus_clk);
               n++;
            end while (bus_in[F_RD_REQ] !== 1'b1 && n < 20);
            @(negedge bus_clk);
            f_wr_ack = 1'b1;
            @(negedge bus_clk);
            f_wr_ack = 1'b0;
            repeat (6) @(negedge bus_clk);
            f_rd_ack = 1'b1;
            f_rdata  = 32'hDEAD_BEEF;
            @(negedge bus_clk);
            f_rd_ack = 1'b0;
            f_rdata  = 32'h0;
         end
      join
      wait_drain();

      // Unmapped read times out; a late ack creates no second response.
      issue(1'b0, 32'h400, 32'h0, 32'hFFFF_FFFF, 1'b1, 10, 1'b1, 1'b0, 1'b0);
      wait_drain();
      repeat (3) @(negedge bus_clk);
      f_rd_ack = 1'b1;
      f_rdata  = 32'h1111_1111;
      @(negedge bus_clk);
      f_rd_ack = 1'b0;
      f_rdata  = 32'h0;
      repeat (4) begin
         @(negedge bus_clk);
         #1 chk("no_late_resp", 64'(hif.resp_valid), 64'd0);
      end
      @(negedge bus_clk);

      // Reset during WAIT drops the transaction.
      issue(1'b1, 32'h400, 32'hCAFE_0005, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge bus_clk);
      bus_reset_l = 1'b0;
      @(negedge bus_clk);
      #1 chk_reset_outputs();
      bus_reset_l = 1'b1;
      repeat (15) @(negedge bus_clk);
      #1 chk("no_resp_after_rst", 64'(hif.resp_valid), 64'd0);
      @(negedge bus_clk);
      issue(1'b1, 32'h1C, 32'h0000_0077, 32'h0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      wait_drain();
      issue(1'b0, 32'h1C, 32'h0, 32'h0000_0077, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      wait_drain();

      repeat (3) @(negedge bus_clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("pulse_count", 64'(pulse_cnt), 64'(acc_cnt));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
